// File: rtl/fix_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fix_alu_pkg
//  Description : Shared types and defaults for the fixed-point ALU blocks.
//  Revision    : 1.0 - initial multi-lane add/sub release
// ============================================================================
package fix_alu_pkg;

    // Per-transaction operation select
    typedef enum logic {
        FIX_OP_ADD = 1'b0,
        FIX_OP_SUB = 1'b1
    } fix_op_e;

    localparam int FIX_DEFAULT_WIDTH = 32;

endpackage : fix_alu_pkg
`default_nettype wire

// File: rtl/fix_addsub_pipe_if.sv
`default_nettype none
// ============================================================================
//  Interface   : fix_addsub_pipe_if
//  Description : Operand/result handshake bundle of the fixed-point add/sub
//                pipeline. master = operand producer / result consumer,
//                slave = the pipeline itself.
//  Revision    : 1.0 - initial multi-lane add/sub release
// ============================================================================
interface fix_addsub_pipe_if
    import fix_alu_pkg::*;
#(
    parameter int WIDTH = FIX_DEFAULT_WIDTH,
    parameter int LANES = 1
) ();

    logic                           flush;
    logic                           in_valid;
    logic                           in_ready;
    fix_op_e                        in_op;
    logic [LANES*WIDTH-1:0]         in_a;
    logic [LANES*WIDTH-1:0]         in_b;
    logic                           out_valid;
    logic                           out_ready;
    logic [LANES*(WIDTH+1)-1:0]     out_data;
    logic [LANES-1:0]               out_ovf;

    modport master (
        output flush, in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );

endinterface : fix_addsub_pipe_if
`default_nettype wire

// File: rtl/fix_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fix_pipe_stage
//  Description : One pipeline register stage carrying {valid, data, ovf}.
//                Flush clears the valid bit and wins over hold; payload only
//                loads when a valid beat advances into the stage.
//  Revision    : 1.0 - initial multi-lane add/sub release
// ============================================================================
module fix_pipe_stage #(
    parameter int DATA_W = 33,
    parameter int LANES  = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_flush,
    input  wire logic              i_load,
    input  wire logic              i_valid,
    input  wire logic [DATA_W-1:0] i_data,
    input  wire logic [LANES-1:0]  i_ovf,
    output      logic              o_valid,
    output      logic [DATA_W-1:0] o_data,
    output      logic [LANES-1:0]  o_ovf
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [LANES-1:0]  r_ovf;

    // Stage register: flush drops the beat, load shifts, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ovf   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
                r_ovf  <= i_ovf;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ovf   = r_ovf;

endmodule : fix_pipe_stage
`default_nettype wire

// File: rtl/fix_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fix_addsub_pipe
//  Description : Multi-lane signed fixed-point add/subtract pipeline with a
//                global-stall valid/ready handshake. Each lane produces an
//                exact WIDTH+1 result; latency equals STAGES.
//                Optional build macro FIX_ADDSUB_SAT_EN: clamp each lane to
//                the WIDTH signed range and report clamping on out_ovf.
//  Revision    : 1.0 - initial multi-lane add/sub release
// ============================================================================
module fix_addsub_pipe
    import fix_alu_pkg::*;
#(
    parameter int WIDTH  = FIX_DEFAULT_WIDTH,
    parameter int LANES  = 1,
    parameter int STAGES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fix_addsub_pipe_if.slave   bus
);

    localparam int c_DATA_W = LANES * (WIDTH + 1);

    logic                w_advance;
    logic [c_DATA_W-1:0] w_res;
    logic [LANES-1:0]    w_res_ovf;

    // Stage chain: index 0 is the combinational adder output feeding stage 1
    logic                w_vld  [0:STAGES];
    logic [c_DATA_W-1:0] w_data [0:STAGES];
    logic [LANES-1:0]    w_ovf  [0:STAGES];

    // The whole pipe moves together whenever the output slot can drain
    assign w_advance    = !w_vld[STAGES] || bus.out_ready;
    assign bus.in_ready = w_advance;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic signed [WIDTH:0] w_a_ext;
            logic signed [WIDTH:0] w_b_ext;
            logic signed [WIDTH:0] w_sum;

            assign w_a_ext = {bus.in_a[i*WIDTH + WIDTH-1], bus.in_a[i*WIDTH +: WIDTH]};
            assign w_b_ext = {bus.in_b[i*WIDTH + WIDTH-1], bus.in_b[i*WIDTH +: WIDTH]};
            assign w_sum   = (bus.in_op == FIX_OP_SUB) ? (w_a_ext - w_b_ext)
                                                       : (w_a_ext + w_b_ext);
`ifdef FIX_ADDSUB_SAT_EN
            // Out of WIDTH range exactly when the two top bits disagree
            logic w_clip;
            assign w_clip        = w_sum[WIDTH] ^ w_sum[WIDTH-1];
            assign w_res_ovf[i]  = w_clip;
            assign w_res[i*(WIDTH+1) +: WIDTH+1] =
                !w_clip      ? w_sum :
                w_sum[WIDTH] ? {2'b11, {(WIDTH-1){1'b0}}}
                             : {2'b00, {(WIDTH-1){1'b1}}};
`else
            assign w_res_ovf[i]  = 1'b0;
            assign w_res[i*(WIDTH+1) +: WIDTH+1] = w_sum;
`endif
        end
    endgenerate

    assign w_vld[0]  = bus.in_valid;
    assign w_data[0] = w_res;
    assign w_ovf[0]  = w_res_ovf;

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            fix_pipe_stage #(
                .DATA_W (c_DATA_W),
                .LANES  (LANES)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_flush (bus.flush),
                .i_load  (w_advance),
                .i_valid (w_vld[s]),
                .i_data  (w_data[s]),
                .i_ovf   (w_ovf[s]),
                .o_valid (w_vld[s+1]),
                .o_data  (w_data[s+1]),
                .o_ovf   (w_ovf[s+1])
            );
        end
    endgenerate

    // Result payload is masked to zero whenever no beat is presented
    assign bus.out_valid = w_vld[STAGES];
    assign bus.out_data  = w_vld[STAGES] ? w_data[STAGES] : '0;
    assign bus.out_ovf   = w_vld[STAGES] ? w_ovf[STAGES]  : '0;

endmodule : fix_addsub_pipe
`default_nettype wire
